mesh_program_loader: RTL and testbench
======================================

Name: mesh_program_loader

Overview:
Upstream feeder for the 4-port mesh. It accepts a 32-bit word stream over a valid/ready handshake and assembles one 64-bit configuration vector plus two 32-bit data loads per input port. It double-buffers the assembled words in shadow registers. On a complete, well-framed program it updates the output registers and asserts load, so the mesh input interfaces capture a consistent program.

Parameters:
NUM_PORTS, 4, number of mesh input ports fed.
DATA_W, 32, stream word width and width of each data load.
CONF_W, 64, configuration vector width; fixed at 2*DATA_W.
LOAD_HOLD, 1, cycles load stays high per program (legal range 1..15).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  stream word valid
in_ready  output  1  loader can accept a word this cycle
in_data  input  DATA_W  stream word
in_last  input  1  marks final word of a program
configuration_vector_port  output  CONF_W x NUM_PORTS  per-port configuration vector
loads  output  DATA_W x NUM_PORTS x 2  per-port data load pair [p][0], [p][1]
load  output  1  program-valid strobe to the mesh
busy  output  1  high while state is LOAD
frame_err  output  1  one-cycle pulse on a framing error
programs_loaded  output  8  count of programs delivered, saturates at 255

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is named clk; reset port is named reset.
- Reset values: in_ready=1, load=0, busy=0, frame_err=0, programs_loaded=0, all configuration_vector_port/loads=0, word index=0, shadow regs=0, state=COLLECT.
- Word order per program, with WPP=4 words per port, for p=0..NUM_PORTS-1:
  - conf[p][31:0]
  - conf[p][63:32]
  - loads[p][0]
  - loads[p][1]
  - Total 4*NUM_PORTS words (16 by default). Index 0 is the first word after reset, a completed program, or an error.
- Handshake: a word transfers when in_valid && in_ready on a rising clk edge. in_data and in_last are sampled only on a transfer. The upstream source may hold in_valid with in_ready low; nothing transfers.
- State COLLECT:
  - in_ready=1.
  - Each transfer writes the shadow slot at the current index and increments the index.
  - Transfer at index < last with in_last=1: framing error. frame_err pulses the next cycle, index returns to 0, shadow keeps stale data, no load. Stay in COLLECT.
  - Transfer at index = last with in_last=0: framing error, same handling.
  - Transfer at index = last with in_last=1: go to LOAD.
- Entry to LOAD (the same edge as the final transfer):
  - Output regs take shadow contents, with the final word merged directly into its slot.
  - load=1, busy=1, in_ready=0 from the next cycle.
  - programs_loaded increments (saturating).
- State LOAD:
  - in_ready=0.
  - load stays high for exactly LOAD_HOLD cycles.
  - Then load=0, busy=0, index=0, in_ready=1, and state returns to COLLECT.
- Outputs are stable at all times except on the LOAD entry edge. Streaming the next program never disturbs them.
- Latency: load rises 1 cycle after the final-word transfer edge, i.e. visible the cycle after the handshake.
- Reset asserted mid-collection or mid-LOAD: all state clears on that edge. A partial program is discarded with no frame_err. load drops immediately.
- frame_err and load never assert in the same cycle.

Test Plan:
1. Back-to-back 16 words, word k = 32'h1000_0000+k, in_last on k=15 -> load high 1 cycle at cycle 17. configuration_vector_port[0]=64'h1000_0001_1000_0000, loads[0][0]=32'h1000_0002, loads[3][1]=32'h1000_000F, programs_loaded=1.
2. in_last on word 7 -> frame_err pulse, no load, outputs unchanged. A following clean 16-word program then loads normally.
3. Word 15 without in_last -> frame_err, no load, index resets to 0.
4. LOAD_HOLD=3, in_valid held high continuously -> load high for 3 cycles, in_ready low for those 3 cycles, no words lost or duplicated, second program loads correctly.
5. Random in_valid gaps (50% duty) -> same outputs as scenario 1. Outputs do not change during the second program's collection until its load.
6. Reset asserted after word 9 -> all outputs 0, no frame_err. The next full program loads with programs_loaded=1. 256 programs -> counter saturates at 255.

Source files
------------

// File: rtl/mesh_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : mesh_program_loader
// Purpose  : Upstream feeder for the mesh input ports. Collects a framed
//            stream of 32-bit words into shadow registers. When a program
//            arrives complete and correctly framed, the shadow contents are
//            transferred in one step to the output registers and a load
//            strobe is raised, so the mesh captures a consistent program.
// Ports    : clk                       - system clock
//            reset                     - synchronous, active-high reset
//            in_valid / in_ready       - stream handshake
//            in_data                   - stream word (DATA_W bits)
//            in_last                   - final word of a program
//            configuration_vector_port - per-port CONF_W configuration vector
//            loads                     - per-port pair of DATA_W data loads
//            load                      - program-valid strobe (LOAD_HOLD cycles)
//            busy                      - high while the load strobe is held
//            frame_err                 - one-cycle pulse on a framing error
//            programs_loaded           - saturating count of delivered programs
// Revision : 1.0 - initial release
// ============================================================================
module mesh_program_loader #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int CONF_W    = 2 * DATA_W,
  parameter int LOAD_HOLD = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_W-1:0]                         in_data,
  input  logic                                      in_last,
  output logic [NUM_PORTS-1:0][CONF_W-1:0]          configuration_vector_port,
  output logic [NUM_PORTS-1:0][1:0][DATA_W-1:0]     loads,
  output logic                                      load,
  output logic                                      busy,
  output logic                                      frame_err,
  output logic [7:0]                                programs_loaded
);

  // Four stream words per port: conf low, conf high, load 0, load 1.
  localparam int WORDS_PER_PORT = 4;
  localparam int WORDS          = WORDS_PER_PORT * NUM_PORTS;
  localparam int IDX_W          = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [3:0]       HOLD_INIT = 4'(LOAD_HOLD - 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_LOAD    = 1'b1
  } state_t;

  state_t                                  state_q, state_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic [3:0]                              hold_q, hold_d;
  logic                                    load_q, load_d;
  logic                                    frame_err_q, frame_err_d;
  logic [7:0]                              cnt_q, cnt_d;
  logic [WORDS-1:0][DATA_W-1:0]            shadow_q, shadow_d;
  logic [NUM_PORTS-1:0][CONF_W-1:0]        conf_q, conf_d;
  logic [NUM_PORTS-1:0][1:0][DATA_W-1:0]   loads_q, loads_d;

  // Shadow image with the final word merged in, so the output registers can
  // be updated on the same edge that accepts the last word.
  logic [WORDS-1:0][DATA_W-1:0]            merged;
  logic [NUM_PORTS-1:0][CONF_W-1:0]        prog_conf;
  logic [NUM_PORTS-1:0][1:0][DATA_W-1:0]   prog_loads;
  logic                                    xfer;

  always_comb begin
    merged           = shadow_q;
    merged[LAST_IDX] = in_data;
  end

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      assign prog_conf[p]     = {merged[WORDS_PER_PORT*p + 1], merged[WORDS_PER_PORT*p]};
      assign prog_loads[p][0] = merged[WORDS_PER_PORT*p + 2];
      assign prog_loads[p][1] = merged[WORDS_PER_PORT*p + 3];
    end
  endgenerate

  assign in_ready = (state_q == ST_COLLECT);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    load_d      = load_q;
    frame_err_d = 1'b0;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    conf_d      = conf_q;
    loads_d     = loads_q;

    case (state_q)
      ST_COLLECT: begin
        if (xfer) begin
          shadow_d[idx_q] = in_data;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_last) begin
              state_d = ST_LOAD;
              load_d  = 1'b1;
              hold_d  = HOLD_INIT;
              conf_d  = prog_conf;
              loads_d = prog_loads;
              if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
              end
            end else begin
              // Program overran its length without a terminator.
              frame_err_d = 1'b1;
            end
          end else if (in_last) begin
            // Terminator arrived early; drop the partial program.
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ST_LOAD: begin
        if (hold_q == 4'd0) begin
          state_d = ST_COLLECT;
          load_d  = 1'b0;
          idx_d   = '0;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        load_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      hold_q      <= '0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      conf_q      <= '0;
      loads_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      conf_q      <= conf_d;
      loads_q     <= loads_d;
    end
  end

  assign configuration_vector_port = conf_q;
  assign loads                     = loads_q;
  assign load                      = load_q;
  assign busy                      = (state_q == ST_LOAD);
  assign frame_err                 = frame_err_q;
  assign programs_loaded           = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mesh_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesh_program_loader
// Purpose  : Directed testbench for mesh_program_loader. Instance dut_a uses
//            LOAD_HOLD=1, instance dut_b uses LOAD_HOLD=3; sel picks which
//            one receives the stream. Delivered programs are checked against
//            a queue of expected programs pushed when stimulus is sent.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesh_program_loader;

  typedef struct {
    logic [3:0][63:0]      conf;
    logic [3:0][1:0][31:0] ld;
    logic [7:0]            cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset, sel, v, l;
  logic [31:0] d;
  logic va, vb;

  logic rdy_a, rdy_b, load_a, load_b, busy_a, busy_b, ferr_a, ferr_b;
  logic [7:0] cnt_a_o, cnt_b_o;
  logic [3:0][63:0]      conf_a, conf_b;
  logic [3:0][1:0][31:0] loads_a, loads_b;

  logic rdy_m, load_m, busy_m, ferr_m;
  logic [7:0] cnt_m;
  logic [3:0][63:0]      conf_m;
  logic [3:0][1:0][31:0] loads_m;

  int tests = 0;
  int fails = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int run = 0;
  logic prev_load = 1'b0;
  logic stable_chk = 1'b0;
  exp_t q[$];
  exp_t last_e;

  always #5 clk = ~clk;

  assign va = v & ~sel;
  assign vb = v & sel;

  mesh_program_loader #(.LOAD_HOLD(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_ready(rdy_a), .in_data(d),
    .in_last(l), .configuration_vector_port(conf_a), .loads(loads_a),
    .load(load_a), .busy(busy_a), .frame_err(ferr_a), .programs_loaded(cnt_a_o)
  );

  mesh_program_loader #(.LOAD_HOLD(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_ready(rdy_b), .in_data(d),
    .in_last(l), .configuration_vector_port(conf_b), .loads(loads_b),
    .load(load_b), .busy(busy_b), .frame_err(ferr_b), .programs_loaded(cnt_b_o)
  );

  assign rdy_m   = sel ? rdy_b   : rdy_a;
  assign load_m  = sel ? load_b  : load_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign ferr_m  = sel ? ferr_b  : ferr_a;
  assign cnt_m   = sel ? cnt_b_o : cnt_a_o;
  assign conf_m  = sel ? conf_b  : conf_a;
  assign loads_m = sel ? loads_b : loads_a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] base, input int cnt);
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      e.conf[p]  = {base + 32'(4*p + 1), base + 32'(4*p)};
      e.ld[p][0] = base + 32'(4*p + 2);
      e.ld[p][1] = base + 32'(4*p + 3);
    end
    e.cnt = (cnt > 255) ? 8'd255 : 8'(cnt);
    return e;
  endfunction

  task automatic chk_outputs(input string tag, input exp_t e);
    for (int p = 0; p < 4; p++) begin
      chk({tag, "_conf"}, conf_m[p], e.conf[p]);
      chk({tag, "_ld0"}, {32'd0, loads_m[p][0]}, {32'd0, e.ld[p][0]});
      chk({tag, "_ld1"}, {32'd0, loads_m[p][1]}, {32'd0, e.ld[p][1]});
    end
  endtask

  // Drive one word and return #1 after the edge on which it transferred.
  task automatic send(input logic [31:0] data, input logic last, input int gap);
    int n;
    logic r;
    if (gap > 0) begin
      v = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    v = 1'b1; d = data; l = last; n = 0;
    forever begin
      @(negedge clk);
      r = rdy_m;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 40) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    v = 1'b0; l = 1'b0;
    if (stable_chk && !last) begin
      chk("stable_conf0", conf_m[0], last_e.conf[0]);
      chk("stable_ld31", {32'd0, loads_m[3][1]}, {32'd0, last_e.ld[3][1]});
    end
  endtask

  task automatic send_prog(input logic [31:0] base, input int nwords, input int last_at,
                           input int maxgap, input logic push);
    exp_t e;
    if (push) begin
      if (sel) begin cnt_b++; e = mk(base, cnt_b); end
      else begin cnt_a++; e = mk(base, cnt_a); end
      q.push_back(e);
    end
    for (int k = 0; k < nwords; k++) begin
      send(base + 32'(k), (k == last_at), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    if (push) last_e = e;
  endtask

  // Scoreboard consumer: checks each delivered program and strobe length.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_load = 1'b0;
      run = 0;
    end else begin
      if (load_m && ferr_m) chk("load_and_ferr", 64'd1, 64'd0);
      if (load_m && rdy_m) chk("ready_during_load", 64'd1, 64'd0);
      if (load_m && !prev_load) begin
        if (q.size() == 0) begin
          chk("unexpected_load", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk_outputs("sb", e);
          chk("sb_count", {56'd0, cnt_m}, {56'd0, e.cnt});
        end
        run = 1;
      end else if (load_m) begin
        run++;
      end
      if (!load_m && prev_load) chk("load_len", 64'(run), sel ? 64'd3 : 64'd1);
      prev_load = load_m;
    end
  end

  initial begin
    exp_t zero_e;
    zero_e = mk(32'd0, 0);
    for (int p = 0; p < 4; p++) begin
      zero_e.conf[p] = '0; zero_e.ld[p] = '0;
    end
    last_e = zero_e;
    reset = 1'b1; sel = 1'b0; v = 1'b0; l = 1'b0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, rdy_m}, 64'd1);
    chk("rst_load", {63'd0, load_m}, 64'd0);
    chk("rst_busy", {63'd0, busy_m}, 64'd0);
    chk("rst_ferr", {63'd0, ferr_m}, 64'd0);
    chk("rst_count", {56'd0, cnt_m}, 64'd0);
    chk_outputs("rst", zero_e);
    reset = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: back-to-back program.
    send_prog(32'h1000_0000, 16, 15, 0, 1'b1);
    chk("s1_load_latency", {63'd0, load_m}, 64'd1);
    chk("s1_busy", {63'd0, busy_m}, 64'd1);
    chk("s1_ready_low", {63'd0, rdy_m}, 64'd0);
    chk("s1_conf0", conf_m[0], 64'h1000_0001_1000_0000);
    chk("s1_ld00", {32'd0, loads_m[0][0]}, 64'h1000_0002);
    chk("s1_ld31", {32'd0, loads_m[3][1]}, 64'h1000_000F);
    chk("s1_count", {56'd0, cnt_m}, 64'd1);
    @(posedge clk); #1;
    chk("s1_load_drop", {63'd0, load_m}, 64'd0);
    chk("s1_ready_back", {63'd0, rdy_m}, 64'd1);

    // Scenario 2: early terminator.
    send_prog(32'h2000_0000, 8, 7, 0, 1'b0);
    chk("s2_ferr", {63'd0, ferr_m}, 64'd1);
    chk("s2_noload", {63'd0, load_m}, 64'd0);
    @(posedge clk); #1;
    chk("s2_ferr_pulse", {63'd0, ferr_m}, 64'd0);
    chk("s2_unchanged", conf_m[0], 64'h1000_0001_1000_0000);
    send_prog(32'h3000_0000, 16, 15, 0, 1'b1);

    // Scenario 3: missing terminator on word 15.
    send_prog(32'h4000_0000, 16, 99, 0, 1'b0);
    chk("s3_ferr", {63'd0, ferr_m}, 64'd1);
    chk("s3_noload", {63'd0, load_m}, 64'd0);
    chk("s3_unchanged", conf_m[1], 64'h3000_0005_3000_0004);
    send_prog(32'h5000_0000, 16, 15, 0, 1'b1);

    // Scenario 5: random valid gaps, outputs stable while collecting.
    stable_chk = 1'b1;
    send_prog(32'h1000_0000, 16, 15, 1, 1'b1);
    chk("s5_conf0", conf_m[0], 64'h1000_0001_1000_0000);
    send_prog(32'h6000_0000, 16, 15, 1, 1'b1);
    stable_chk = 1'b0;

    // Scenario 6: reset after word 9, then counter saturation.
    send_prog(32'h7700_0000, 10, 99, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_a = 0;
    chk("s6_count0", {56'd0, cnt_m}, 64'd0);
    chk("s6_load0", {63'd0, load_m}, 64'd0);
    chk("s6_ferr0", {63'd0, ferr_m}, 64'd0);
    chk_outputs("s6_rst", zero_e);
    @(posedge clk); #1;
    chk("s6_ferr_after", {63'd0, ferr_m}, 64'd0);
    send_prog(32'h7000_0000, 16, 15, 0, 1'b1);
    chk("s6_count1", {56'd0, cnt_m}, 64'd1);
    for (int i = 0; i < 255; i++) begin
      send_prog(32'h8000_0000 + 32'(i << 8), 16, 15, 0, 1'b1);
    end
    @(posedge clk); #1;
    chk("s6_saturate", {56'd0, cnt_m}, 64'd255);

    // Scenario 4: LOAD_HOLD=3 instance, valid held high across programs.
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b1;
    send_prog(32'h9000_0000, 16, 15, 0, 1'b1);
    send_prog(32'hA000_0000, 16, 15, 0, 1'b1);
    chk("s4_count", {56'd0, cnt_m}, 64'd2);
    repeat (6) @(posedge clk);
    #1;
    chk("s4_ld31", {32'd0, loads_m[3][1]}, 64'hA000_000F);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
